// File: rtl/spi_ram_pkg.sv
// rtl/spi_ram_pkg.sv - shared command encoding, widths and arbiter states
package spi_ram_pkg;

    localparam int DEFAULT_ADDR_W = 8;
    localparam int CMD_BITS       = 2;
    localparam int CMD_WORD_W     = DEFAULT_ADDR_W + CMD_BITS;

    localparam logic [CMD_BITS-1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [CMD_BITS-1:0] CMD_WR_DATA = 2'b01;
    localparam logic [CMD_BITS-1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [CMD_BITS-1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPI_LOCK,
        ST_H_ADDR,
        ST_H_DATA,
        ST_H_WAIT,
        ST_H_ACK
    } arb_state_e;

    function automatic logic is_addr_cmd(input logic [CMD_BITS-1:0] cmd);
        return (cmd == CMD_WR_ADDR) || (cmd == CMD_RD_ADDR);
    endfunction

endpackage

// File: rtl/spi_word_buffer.sv
// rtl/spi_word_buffer.sv - one-entry SPI word holding register with sticky overflow
module spi_word_buffer
    import spi_ram_pkg::*;
#(
    parameter int W = CMD_WORD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_tvalid,
    input  logic [W-1:0] s_tdata,
    output logic         m_tvalid,
    output logic [W-1:0] m_tdata,
    input  logic         m_tready,
    output logic         ovf
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            ovf      <= 1'b0;
        end else begin
            // A drain frees the slot in the same cycle, so capture-while-draining is legal
            if (s_tvalid && (!m_tvalid || m_tready)) begin
                m_tvalid <= 1'b1;
                m_tdata  <= s_tdata;
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end
            if (s_tvalid && m_tvalid && !m_tready) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_access_arbiter.sv
// rtl/ram_access_arbiter.sv - shares the command RAM between the SPI word stream and a host port
module ram_access_arbiter
    import spi_ram_pkg::*;
#(
    parameter int LOCK_TIMEOUT = 64,
    parameter int ADDR_WIDTH   = DEFAULT_ADDR_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           spi_rx_valid,
    input  logic [ADDR_WIDTH+CMD_BITS-1:0] spi_rx_data,
    output logic                           spi_tx_valid,
    output logic [ADDR_WIDTH-1:0]          spi_tx_data,
    input  logic                           host_req,
    input  logic                           host_we,
    input  logic [ADDR_WIDTH-1:0]          host_addr,
    input  logic [ADDR_WIDTH-1:0]          host_wdata,
    output logic                           host_ack,
    output logic [ADDR_WIDTH-1:0]          host_rdata,
    output logic [ADDR_WIDTH+CMD_BITS-1:0] ram_din,
    output logic                           ram_rx_valid,
    input  logic [ADDR_WIDTH-1:0]          ram_dout,
    input  logic                           ram_tx_valid,
    output logic                           spi_ovf
);

    localparam int WORD_W = ADDR_WIDTH + CMD_BITS;
    localparam int CNT_W  = $clog2(LOCK_TIMEOUT + 1);

    logic                buf_valid;
    logic [WORD_W-1:0]   buf_data;
    logic [CMD_BITS-1:0] buf_cmd;
    logic                buf_drain;

    arb_state_e          state, state_nx;
    logic [CNT_W-1:0]    lock_cnt, lock_cnt_nx, lock_cnt_inc;
    logic                owner_spi, owner_spi_nx;
    logic                host_rd_op, host_rd_op_nx;
    logic                issue;
    logic [WORD_W-1:0]   issue_word;
    logic                ack_nx;
    logic                rdata_ld;

    spi_word_buffer #(.W(WORD_W)) u_spi_word_buffer (
        .clk      (clk),
        .rst      (rst),
        .s_tvalid (spi_rx_valid),
        .s_tdata  (spi_rx_data),
        .m_tvalid (buf_valid),
        .m_tdata  (buf_data),
        .m_tready (buf_drain),
        .ovf      (spi_ovf)
    );

    assign buf_cmd      = buf_data[WORD_W-1 -: CMD_BITS];
    assign lock_cnt_inc = lock_cnt + 1'b1;

    always_comb begin
        state_nx      = state;
        lock_cnt_nx   = lock_cnt;
        owner_spi_nx  = owner_spi;
        host_rd_op_nx = host_rd_op;
        issue         = 1'b0;
        issue_word    = buf_data;
        buf_drain     = 1'b0;
        ack_nx        = 1'b0;
        rdata_ld      = 1'b0;
        case (state)
            ST_IDLE, ST_SPI_LOCK: begin
                // Buffered SPI words win over the host; an address word holds the RAM for its data word
                if (buf_valid) begin
                    issue       = 1'b1;
                    buf_drain   = 1'b1;
                    lock_cnt_nx = '0;
                    state_nx    = is_addr_cmd(buf_cmd) ? ST_SPI_LOCK : ST_IDLE;
                    if (buf_cmd == CMD_RD_DATA) begin
                        owner_spi_nx = 1'b1;
                    end
                end else if (state == ST_SPI_LOCK) begin
                    if (lock_cnt_inc == CNT_W'(LOCK_TIMEOUT)) begin
                        lock_cnt_nx = '0;
                        state_nx    = ST_IDLE;
                    end else begin
                        lock_cnt_nx = lock_cnt_inc;
                    end
                end else if (host_req) begin
                    state_nx = ST_H_ADDR;
                end
            end
            ST_H_ADDR: begin
                issue         = 1'b1;
                issue_word    = {(host_we ? CMD_WR_ADDR : CMD_RD_ADDR), host_addr};
                host_rd_op_nx = !host_we;
                state_nx      = ST_H_DATA;
            end
            ST_H_DATA: begin
                issue      = 1'b1;
                issue_word = {(host_rd_op ? CMD_RD_DATA : CMD_WR_DATA), host_wdata};
                if (host_rd_op) begin
                    owner_spi_nx = 1'b0;
                    state_nx     = ST_H_WAIT;
                end else begin
                    state_nx = ST_H_ACK;
                end
            end
            ST_H_WAIT: begin
                // Read ack goes out with the captured data; H_ACK then only pulses for writes
                if (ram_tx_valid && !owner_spi) begin
                    rdata_ld = 1'b1;
                    ack_nx   = 1'b1;
                    state_nx = ST_H_ACK;
                end
            end
            ST_H_ACK: begin
                ack_nx   = !host_rd_op;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            lock_cnt     <= '0;
            owner_spi    <= 1'b0;
            host_rd_op   <= 1'b0;
            ram_din      <= '0;
            ram_rx_valid <= 1'b0;
            host_ack     <= 1'b0;
            host_rdata   <= '0;
        end else begin
            state        <= state_nx;
            lock_cnt     <= lock_cnt_nx;
            owner_spi    <= owner_spi_nx;
            host_rd_op   <= host_rd_op_nx;
            ram_rx_valid <= issue;
            host_ack     <= ack_nx;
            if (issue) begin
                ram_din <= issue_word;
            end
            if (rdata_ld) begin
                host_rdata <= ram_dout;
            end
        end
    end

    assign spi_tx_valid = ram_tx_valid && owner_spi;
    assign spi_tx_data  = spi_tx_valid ? ram_dout : '0;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb/tb_ram_access_arbiter.sv - self-checking bench for ram_access_arbiter
module tb_ram_access_arbiter;
    import spi_ram_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       spi_rx_valid = 1'b0;
    logic [9:0] spi_rx_data = '0;
    logic       spi_tx_valid;
    logic [7:0] spi_tx_data;
    logic       host_req = 1'b0;
    logic       host_we = 1'b0;
    logic [7:0] host_addr = '0;
    logic [7:0] host_wdata = '0;
    logic       host_ack;
    logic [7:0] host_rdata;
    logic [9:0] ram_din;
    logic       ram_rx_valid;
    bit   [7:0] ram_dout;
    bit         ram_tx_valid;
    logic       spi_ovf;

    int errors = 0;
    int checks = 0;

    bit   [7:0] mem [256];
    bit   [7:0] shadow [256];
    bit   [7:0] ram_wa, ram_ra;

    always #5 clk = ~clk;

    ram_access_arbiter #(.LOCK_TIMEOUT(64), .ADDR_WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .spi_rx_valid (spi_rx_valid),
        .spi_rx_data  (spi_rx_data),
        .spi_tx_valid (spi_tx_valid),
        .spi_tx_data  (spi_tx_data),
        .host_req     (host_req),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_ack     (host_ack),
        .host_rdata   (host_rdata),
        .ram_din      (ram_din),
        .ram_rx_valid (ram_rx_valid),
        .ram_dout     (ram_dout),
        .ram_tx_valid (ram_tx_valid),
        .spi_ovf      (spi_ovf)
    );

    // Single-port command RAM: read data returns one cycle after RD_DATA
    always @(posedge clk) begin
        ram_tx_valid <= 1'b0;
        if (ram_rx_valid === 1'b1) begin
            case (ram_din[9:8])
                2'b00: ram_wa <= ram_din[7:0];
                2'b01: mem[ram_wa] <= ram_din[7:0];
                2'b10: ram_ra <= ram_din[7:0];
                default: begin
                    ram_tx_valid <= 1'b1;
                    ram_dout     <= mem[ram_ra];
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic host_op(input logic we, input logic [7:0] a, input logic [7:0] d,
                           output logic [7:0] rd, output int lat);
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d; lat = 0;
        do begin
            tick();
            lat++;
        end while (host_ack !== 1'b1 && lat < 200);
        rd = host_rdata;
        host_req = 1'b0;
        tick();
    endtask

    task automatic spi_word(input logic [9:0] w, output logic got, output logic [7:0] gd);
        spi_rx_valid = 1'b1; spi_rx_data = w;
        tick();
        spi_rx_valid = 1'b0; got = 1'b0; gd = '0;
        repeat (9) begin
            tick();
            if (spi_tx_valid === 1'b1) begin
                got = 1'b1;
                gd  = spi_tx_data;
            end
        end
    endtask

    logic [7:0] rd, a, d;
    logic       got;
    int         lat, n, strobes, kind;

    initial begin
        // Reset with busy inputs: all outputs must stay at zero
        spi_rx_valid = 1'b1; spi_rx_data = 10'h3FF; host_req = 1'b1;
        repeat (3) tick();
        check("rst_rx_valid", ram_rx_valid, 0);
        check("rst_din", ram_din, 0);
        check("rst_ack", host_ack, 0);
        check("rst_rdata", host_rdata, 0);
        check("rst_spi_tx", spi_tx_valid, 0);
        check("rst_ovf", spi_ovf, 0);
        spi_rx_valid = 1'b0; host_req = 1'b0; rst = 1'b1;
        tick();

        // SPI write pair, host idle: each command one cycle after its strobe
        spi_rx_valid = 1'b1; spi_rx_data = 10'h0A5; tick(); spi_rx_valid = 1'b0;
        check("spi_wa_lat0", ram_rx_valid, 0);
        tick();
        check("spi_wa_rv", ram_rx_valid, 1);
        check("spi_wa_din", ram_din, 10'h0A5);
        repeat (9) tick();
        spi_rx_valid = 1'b1; spi_rx_data = 10'h13C; tick(); spi_rx_valid = 1'b0;
        tick();
        check("spi_wd_rv", ram_rx_valid, 1);
        check("spi_wd_din", ram_din, 10'h13C);
        check("spi_no_ack", host_ack, 0);
        shadow[8'hA5] = 8'h3C;
        repeat (9) tick();

        // Host write 0x20 <= 0x77 with exact cycle timing
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h20; host_wdata = 8'h77;
        tick();
        check("hw_k0_rv", ram_rx_valid, 0);
        tick();
        check("hw_addr", {ram_rx_valid, ram_din}, {1'b1, 10'h020});
        tick();
        check("hw_data", {ram_rx_valid, ram_din}, {1'b1, 10'h177});
        check("hw_ack_early", host_ack, 0);
        tick();
        check("hw_ack", host_ack, 1);
        host_req = 1'b0;
        tick();
        check("hw_ack_pulse", host_ack, 0);
        shadow[8'h20] = 8'h77;
        host_op(1'b1, 8'h10, 8'hC3, rd, lat);
        check("hw2_lat", lat, 4);
        shadow[8'h10] = 8'hC3;

        // Host read 0x20: data routed to host only
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20; host_wdata = 8'h00;
        tick(); tick();
        check("hr_addr", {ram_rx_valid, ram_din}, {1'b1, 10'h220});
        tick();
        check("hr_data", {ram_rx_valid, ram_din}, {1'b1, 10'h300});
        tick();
        check("hr_no_spi_tx", spi_tx_valid, 0);
        check("hr_ack_early", host_ack, 0);
        tick();
        check("hr_ack", host_ack, 1);
        check("hr_rdata", host_rdata, shadow[8'h20]);
        host_req = 1'b0;
        tick();
        check("hr_rdata_hold", {host_ack, host_rdata}, {1'b0, shadow[8'h20]});

        // SPI address lock blocks a host write until the SPI read completes
        spi_rx_valid = 1'b1; spi_rx_data = 10'h210; tick(); spi_rx_valid = 1'b0;
        tick();
        check("lk_addr", {ram_rx_valid, ram_din}, {1'b1, 10'h210});
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h31; host_wdata = 8'h5A;
        strobes = 0;
        repeat (10) begin
            tick();
            if (ram_rx_valid === 1'b1) strobes++;
        end
        check("lk_host_blocked", strobes, 0);
        spi_rx_valid = 1'b1; spi_rx_data = 10'h300; tick(); spi_rx_valid = 1'b0;
        tick();
        check("lk_rd_data", {ram_rx_valid, ram_din}, {1'b1, 10'h300});
        tick();
        check("lk_spi_tx", {spi_tx_valid, spi_tx_data}, {1'b1, shadow[8'h10]});
        check("lk_gap", ram_rx_valid, 0);
        tick();
        check("lk_host_addr", {ram_rx_valid, ram_din}, {1'b1, 10'h031});
        tick();
        check("lk_host_data", {ram_rx_valid, ram_din}, {1'b1, 10'h15A});
        tick();
        check("lk_host_ack", host_ack, 1);
        host_req = 1'b0;
        tick();
        shadow[8'h31] = 8'h5A;

        // Orphan SPI address: lock holds 64 cycles, then the pending host read runs
        spi_rx_valid = 1'b1; spi_rx_data = 10'h044; tick(); spi_rx_valid = 1'b0;
        tick();
        check("to_addr", {ram_rx_valid, ram_din}, {1'b1, 10'h044});
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h31; host_wdata = 8'h00;
        n = 0;
        do begin
            tick();
            n++;
        end while (ram_rx_valid !== 1'b1 && n < 200);
        check("to_release_cycles", n, 66);
        check("to_host_addr", ram_din, 10'h231);
        n = 0;
        do begin
            tick();
            n++;
        end while (host_ack !== 1'b1 && n < 20);
        check("to_ack_cycles", n, 3);
        check("to_rdata", host_rdata, shadow[8'h31]);
        host_req = 1'b0;
        tick();

        // Capture while draining at the end of a host write does not overflow
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h40; host_wdata = 8'h12;
        tick(); tick(); tick();
        spi_rx_valid = 1'b1; spi_rx_data = 10'h066;
        tick();
        check("dc_ack", host_ack, 1);
        host_req = 1'b0; spi_rx_data = 10'h199;
        tick();
        spi_rx_valid = 1'b0;
        check("dc_w1", {ram_rx_valid, ram_din}, {1'b1, 10'h066});
        tick();
        check("dc_w2", {ram_rx_valid, ram_din}, {1'b1, 10'h199});
        check("dc_no_ovf", spi_ovf, 0);
        shadow[8'h40] = 8'h12;
        shadow[8'h66] = 8'h99;
        repeat (8) tick();

        // Three back-to-back SPI words during a host read: buffer holds one
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20; host_wdata = 8'h00;
        tick(); tick();
        spi_rx_valid = 1'b1; spi_rx_data = 10'h055;
        tick();
        check("ov_first_ok", spi_ovf, 0);
        spi_rx_data = 10'h1EE;
        tick();
        check("ov_set", spi_ovf, 1);
        spi_rx_data = 10'h1DD;
        tick();
        check("ov_host_ack", {host_ack, host_rdata}, {1'b1, shadow[8'h20]});
        spi_rx_valid = 1'b0; host_req = 1'b0;
        tick();
        check("ov_wait", ram_rx_valid, 0);
        tick();
        check("ov_w1_served", {ram_rx_valid, ram_din}, {1'b1, 10'h055});
        strobes = 0;
        repeat (9) begin
            tick();
            if (ram_rx_valid === 1'b1) strobes++;
        end
        check("ov_dropped", strobes, 0);
        spi_word(10'h1AB, got, rd);
        shadow[8'h55] = 8'hAB;

        // Random serialised traffic against the shadow memory
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            a = 8'($urandom);
            d = 8'($urandom);
            case (kind)
                0: begin
                    host_op(1'b1, a, d, rd, lat);
                    check("rnd_hw_lat", lat, 4);
                    shadow[a] = d;
                end
                1: begin
                    host_op(1'b0, a, d, rd, lat);
                    check("rnd_hr_lat", lat, 5);
                    check("rnd_hr_data", rd, shadow[a]);
                end
                2: begin
                    spi_word({CMD_WR_ADDR, a}, got, rd);
                    spi_word({CMD_WR_DATA, d}, got, rd);
                    shadow[a] = d;
                end
                default: begin
                    spi_word({CMD_RD_ADDR, a}, got, rd);
                    spi_word({CMD_RD_DATA, d}, got, rd);
                    check("rnd_sr_data", {got, rd}, {1'b1, shadow[a]});
                end
            endcase
            repeat ($urandom_range(0, 3)) tick();
        end
        check("ovf_sticky", spi_ovf, 1);

        // Reset in the middle of a host read abandons it
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h66; host_wdata = 8'h00;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("mr_outputs", {ram_rx_valid, ram_din, host_ack, host_rdata, spi_tx_valid}, 0);
        check("mr_ovf", spi_ovf, 0);
        host_req = 1'b0;
        tick(); tick();
        rst = 1'b1;
        strobes = 0;
        repeat (6) begin
            tick();
            if (host_ack === 1'b1 || ram_rx_valid === 1'b1) strobes++;
        end
        check("mr_no_ack", strobes, 0);
        host_op(1'b0, 8'h66, 8'h00, rd, lat);
        check("mr_reread", {lat[7:0], rd}, {8'd5, shadow[8'h66]});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
